// File: rtl/player_move_ctrl_if.sv
// Map cell read bus between the player movement controller and the maze map.
// The controller issues a read strobe with a cell address; the map returns the
// wall bit of that cell one clock later.
interface player_move_ctrl_if;
  logic       map_rd;
  logic [5:0] map_x;
  logic [5:0] map_y;
  logic       map_wall;

  modport master (output map_rd, output map_x, output map_y, input map_wall);
  modport slave  (input map_rd, input map_x, input map_y, output map_wall);
endinterface

// File: rtl/player_move_ctrl.sv
// Player movement controller for a 41x41 maze with a 4x4-cell player sprite.
// Accepts single-cell move requests, checks the leading-edge cells for walls
// via the map read bus and updates the player position.
// Optional feature macro: PLAYER_COLLISION_EN (wall checking); when undefined,
// only the maze-border rule blocks a move.
module player_move_ctrl #(
  parameter int unsigned START_X = 36,
  parameter int unsigned START_Y = 35
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          state,
  input  logic                move_req,
  input  logic [1:0]          dir,
  output logic                busy,
  player_move_ctrl_if.master  map,
  output logic [5:0]          pos_x,
  output logic [5:0]          pos_y,
  output logic                moved,
  output logic                blocked,
  output logic                goal
);

  localparam logic [5:0] SX      = 6'(START_X);
  localparam logic [5:0] SY      = 6'(START_Y);
  localparam logic [5:0] MAX_POS = 6'd37;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} fsm_t;

  fsm_t       fsm;
  logic [1:0] dir_q;
  logic [5:0] tgt_x;
  logic [5:0] tgt_y;
  logic       hit;
  logic [1:0] k;

  logic       play;
  logic       at_edge;
  logic [5:0] nxt_x;
  logic [5:0] nxt_y;

  // Leading-edge cell k for a move in direction d from top-left (px, py).
  function automatic logic [11:0] edge_cell(input logic [1:0] d,
                                            input logic [5:0] px,
                                            input logic [5:0] py,
                                            input logic [1:0] idx);
    logic [5:0] cx;
    logic [5:0] cy;
    case (d)
      2'd0:    begin cx = px + 6'(idx); cy = py - 6'd1;    end
      2'd1:    begin cx = px + 6'(idx); cy = py + 6'd4;    end
      2'd2:    begin cx = px - 6'd1;    cy = py + 6'(idx); end
      default: begin cx = px + 6'd4;    cy = py + 6'(idx); end
    endcase
    return {cx, cy};
  endfunction

  // Play-state decode, border rule and one-cell target position.
  always_comb begin
    play    = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    at_edge = 1'b0;
    nxt_x   = pos_x;
    nxt_y   = pos_y;
    case (dir)
      2'd0:    begin at_edge = (pos_y == 6'd0);    nxt_y = pos_y - 6'd1; end
      2'd1:    begin at_edge = (pos_y == MAX_POS); nxt_y = pos_y + 6'd1; end
      2'd2:    begin at_edge = (pos_x == 6'd0);    nxt_x = pos_x - 6'd1; end
      default: begin at_edge = (pos_x == MAX_POS); nxt_x = pos_x + 6'd1; end
    endcase
  end

  // Move FSM with registered outputs; leaving play aborts and reloads the start cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      dir_q      <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      hit        <= 1'b0;
      k          <= '0;
      pos_x      <= SX;
      pos_y      <= SY;
      busy       <= 1'b0;
      map.map_rd <= 1'b0;
      map.map_x  <= '0;
      map.map_y  <= '0;
      moved      <= 1'b0;
      blocked    <= 1'b0;
      goal       <= 1'b0;
    end else if (!play) begin
      fsm        <= IDLE;
      hit        <= 1'b0;
      k          <= '0;
      pos_x      <= SX;
      pos_y      <= SY;
      busy       <= 1'b0;
      map.map_rd <= 1'b0;
      map.map_x  <= '0;
      map.map_y  <= '0;
      moved      <= 1'b0;
      blocked    <= 1'b0;
      goal       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (move_req) begin
            dir_q <= dir;
            tgt_x <= nxt_x;
            tgt_y <= nxt_y;
            busy  <= 1'b1;
            if (at_edge) begin
              blocked <= 1'b1;
              fsm     <= DONE;
            end else begin
`ifdef PLAYER_COLLISION_EN
              fsm                      <= CHECK;
              hit                      <= 1'b0;
              k                        <= '0;
              map.map_rd               <= 1'b1;
              {map.map_x, map.map_y}   <= edge_cell(dir, pos_x, pos_y, 2'd0);
`else
              pos_x <= nxt_x;
              pos_y <= nxt_y;
              moved <= 1'b1;
              goal  <= (nxt_x == 6'd0);
              fsm   <= DONE;
`endif
            end
          end
        end
        CHECK: begin
          // map_wall answers the read issued one cycle earlier, so the first
          // CHECK cycle has nothing to accumulate yet.
          if (k != 2'd0) hit <= hit | map.map_wall;
          if (k == 2'd3) begin
            fsm        <= WAIT;
            map.map_rd <= 1'b0;
            map.map_x  <= '0;
            map.map_y  <= '0;
          end else begin
            k                      <= k + 2'd1;
            {map.map_x, map.map_y} <= edge_cell(dir_q, pos_x, pos_y, k + 2'd1);
          end
        end
        WAIT: begin
          fsm <= DONE;
          if (hit | map.map_wall) begin
            blocked <= 1'b1;
          end else begin
            pos_x <= tgt_x;
            pos_y <= tgt_y;
            moved <= 1'b1;
            goal  <= (tgt_x == 6'd0);
          end
        end
        default: begin
          moved   <= 1'b0;
          blocked <= 1'b0;
          goal    <= 1'b0;
          busy    <= 1'b0;
          fsm     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed self-checking bench for player_move_ctrl. Adapts its expected
// latencies to whether PLAYER_COLLISION_EN is defined.
module tb_player_move_ctrl;

`ifdef PLAYER_COLLISION_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd2;
  logic       move_req = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       busy;
  logic [5:0] pos_x, pos_y;
  logic       moved, blocked, goal;

  player_move_ctrl_if mif();

  player_move_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .move_req (move_req),
    .dir      (dir),
    .busy     (busy),
    .map      (mif),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .moved    (moved),
    .blocked  (blocked),
    .goal     (goal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Map model: either every cell is a wall, or only (wall_x, wall_y).
  logic       all_walls = 1'b0;
  logic [5:0] wall_x = 6'd63;
  logic [5:0] wall_y = 6'd63;
  int rd_x[$];
  int rd_y[$];
  int rd_seen = 0;
  int addr_leak = 0;
  int excl_bad = 0;
  int mx = 36;
  int my = 35;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mif.map_wall <= 1'b0;
    else mif.map_wall <= mif.map_rd &&
                         (all_walls || (mif.map_x == wall_x && mif.map_y == wall_y));
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (mif.map_rd) begin
        rd_x.push_back(int'(mif.map_x));
        rd_y.push_back(int'(mif.map_y));
        rd_seen++;
      end else if (mif.map_x != 6'd0 || mif.map_y != 6'd0) begin
        addr_leak++;
      end
      if ((moved && blocked) || (goal && !moved)) excl_bad++;
    end
  end

  task automatic issue(input logic [1:0] d);
    @(negedge clk);
    move_req = 1'b1;
    dir = d;
    @(negedge clk);
    move_req = 1'b0;
  endtask

  // Returns the number of negedges after the accepting edge until a pulse shows.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!(moved || blocked || goal) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (pos_x !== 6'd36 || pos_y !== 6'd35) begin
      failures++; $display("FAIL reset_pos got=(%0d,%0d) want=(36,35)", pos_x, pos_y);
    end
    checks++;
    if ({busy, mif.map_rd, moved, blocked, goal} !== 5'b0 || mif.map_x !== 6'd0 || mif.map_y !== 6'd0) begin
      failures++; $display("FAIL reset_outs got=%b x=%0d y=%0d want=0", {busy, mif.map_rd, moved, blocked, goal}, mif.map_x, mif.map_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef PLAYER_COLLISION_EN
  task automatic test_right_blocked();
    int lat;
    all_walls = 1'b1;
    rd_x.delete(); rd_y.delete();
    issue(2'd3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept got=%b want=1", busy); end
    wait_result(lat);
    checks++;
    if (lat != 6 || {moved, blocked, goal} !== 3'b010) begin
      failures++; $display("FAIL right_blocked lat=%0d mbg=%b want lat=6 mbg=010", lat, {moved, blocked, goal});
    end
    checks++;
    if (rd_x.size() != 4) begin
      failures++; $display("FAIL right_reads count=%0d want=4", rd_x.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rd_x[i] != 40 || rd_y[i] != 35 + i) begin
          failures++; $display("FAIL right_read%0d got=(%0d,%0d) want=(40,%0d)", i, rd_x[i], rd_y[i], 35 + i);
          break;
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, moved, blocked} !== 3'b0 || pos_x !== 6'd36 || pos_y !== 6'd35) begin
      failures++; $display("FAIL right_after busy=%b pos=(%0d,%0d) want busy=0 pos=(36,35)", busy, pos_x, pos_y);
    end
    all_walls = 1'b0;
  endtask

  task automatic test_up_move();
    int lat;
    rd_x.delete(); rd_y.delete();
    issue(2'd0);
    wait_result(lat);
    checks++;
    if (lat != 6 || {moved, blocked, goal} !== 3'b100 || pos_x !== 6'd36 || pos_y !== 6'd34) begin
      failures++; $display("FAIL up_move lat=%0d mbg=%b pos=(%0d,%0d) want lat=6 mbg=100 pos=(36,34)", lat, {moved, blocked, goal}, pos_x, pos_y);
    end
    checks++;
    if (rd_x.size() != 4) begin
      failures++; $display("FAIL up_reads count=%0d want=4", rd_x.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rd_x[i] != 36 + i || rd_y[i] != 34) begin
          failures++; $display("FAIL up_read%0d got=(%0d,%0d) want=(%0d,34)", i, rd_x[i], rd_y[i], 36 + i);
          break;
        end
      end
    end
    my = 34;
  endtask

  task automatic test_partial_walls();
    int lat;
    // Wall only under the last leading-edge cell: caught by the WAIT cycle.
    wall_x = 6'd39; wall_y = 6'd38;
    issue(2'd1);
    wait_result(lat);
    checks++;
    if (lat != 6 || {moved, blocked} !== 2'b01 || pos_y !== 6'd34) begin
      failures++; $display("FAIL wall_last lat=%0d mb=%b pos_y=%0d want lat=6 mb=01 pos_y=34", lat, {moved, blocked}, pos_y);
    end
    // Wall only on the first leading-edge cell.
    wall_x = 6'd36; wall_y = 6'd33;
    issue(2'd0);
    wait_result(lat);
    checks++;
    if (lat != 6 || {moved, blocked} !== 2'b01 || pos_y !== 6'd34) begin
      failures++; $display("FAIL wall_first lat=%0d mb=%b pos_y=%0d want lat=6 mb=01 pos_y=34", lat, {moved, blocked}, pos_y);
    end
    wall_x = 6'd63; wall_y = 6'd63;
  endtask
`else
  task automatic test_nocoll_down();
    int lat;
    all_walls = 1'b1;
    issue(2'd1);
    wait_result(lat);
    checks++;
    if (lat != 1 || {moved, blocked, goal} !== 3'b100 || pos_x !== 6'd36 || pos_y !== 6'd36) begin
      failures++; $display("FAIL nocoll_down lat=%0d mbg=%b pos=(%0d,%0d) want lat=1 mbg=100 pos=(36,36)", lat, {moved, blocked, goal}, pos_x, pos_y);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || moved !== 1'b0) begin
      failures++; $display("FAIL nocoll_after busy=%b moved=%b want 0 0", busy, moved);
    end
    all_walls = 1'b0;
    my = 36;
  endtask
`endif

  task automatic drive_to(input int tx, input int ty);
    int lat;
    while (mx > tx) begin issue(2'd2); wait_result(lat); mx--; end
    while (my > ty) begin issue(2'd0); wait_result(lat); my--; end
    checks++;
    if (pos_x !== 6'(tx) || pos_y !== 6'(ty)) begin
      failures++; $display("FAIL drive_to got=(%0d,%0d) want=(%0d,%0d)", pos_x, pos_y, tx, ty);
    end
  endtask

  task automatic test_goal_edge();
    int lat;
    int seen;
    drive_to(1, 17);
    rd_x.delete(); rd_y.delete();
    issue(2'd2);
    wait_result(lat);
    checks++;
    if (lat != LAT || {moved, blocked, goal} !== 3'b101 || pos_x !== 6'd0 || pos_y !== 6'd17) begin
      failures++; $display("FAIL goal lat=%0d mbg=%b pos=(%0d,%0d) want lat=%0d mbg=101 pos=(0,17)", lat, {moved, blocked, goal}, pos_x, pos_y, LAT);
    end
`ifdef PLAYER_COLLISION_EN
    checks++;
    if (rd_x.size() != 4 || rd_x[0] != 0 || rd_y[0] != 17 || rd_y[3] != 20) begin
      failures++; $display("FAIL goal_reads count=%0d want 4 reads (0,17..20)", rd_x.size());
    end
`endif
    mx = 0;
    seen = rd_seen;
    issue(2'd2);
    wait_result(lat);
    checks++;
    if (lat != 1 || {moved, blocked, goal} !== 3'b010 || pos_x !== 6'd0 || rd_seen != seen) begin
      failures++; $display("FAIL left_edge lat=%0d mbg=%b pos_x=%0d reads=%0d want lat=1 mbg=010 pos_x=0 reads=0", lat, {moved, blocked, goal}, pos_x, rd_seen - seen);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk);
    move_req = 1'b1;
    dir = 2'd3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (moved || blocked) begin pulses++; break; end
    end
    // Request stays high through the DONE cycle, then drops.
    @(negedge clk);
    move_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (moved || blocked) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 1 || busy !== 1'b0 || pos_x !== 6'd1 || pos_y !== 6'd17) begin
      failures++; $display("FAIL back_to_back pulses=%0d busy=%b pos=(%0d,%0d) want pulses=1 busy=0 pos=(1,17)", pulses, busy, pos_x, pos_y);
    end
    mx = 1;
  endtask

  task automatic test_state_leave();
    int pulses = 0;
    int busy_hi = 0;
    int lat;
`ifdef PLAYER_COLLISION_EN
    issue(2'd3);
    state = 4'd3;
`else
    issue(2'd3);
    wait_result(lat);
    state = 4'd3;
`endif
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mif.map_rd !== 1'b0 || pos_x !== 6'd36 || pos_y !== 6'd35) begin
      failures++; $display("FAIL state_leave busy=%b map_rd=%b pos=(%0d,%0d) want 0 0 (36,35)", busy, mif.map_rd, pos_x, pos_y);
    end
    for (int i = 0; i < 8; i++) begin
      if (moved || blocked || goal) pulses++;
      @(negedge clk);
    end
    move_req = 1'b1;
    dir = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      move_req = 1'b0;
      if (moved || blocked || goal) pulses++;
      if (busy) busy_hi++;
    end
    checks++;
    if (pulses != 0 || busy_hi != 0 || pos_x !== 6'd36 || pos_y !== 6'd35) begin
      failures++; $display("FAIL nonplay_ignore pulses=%0d busy_cycles=%0d pos=(%0d,%0d) want 0 0 (36,35)", pulses, busy_hi, pos_x, pos_y);
    end
    state = 4'd2;
    mx = 36; my = 35;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int lat;
    issue(2'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mif.map_rd, moved, blocked, goal} !== 5'b0 || pos_x !== 6'd36 || pos_y !== 6'd35) begin
      failures++; $display("FAIL async_reset outs=%b pos=(%0d,%0d) want 0 (36,35)", {busy, mif.map_rd, moved, blocked, goal}, pos_x, pos_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (moved || blocked || goal) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL reset_discard pulses=%0d want=0", pulses); end
    issue(2'd0);
    wait_result(lat);
    checks++;
    if (lat != LAT || moved !== 1'b1 || pos_x !== 6'd36 || pos_y !== 6'd34) begin
      failures++; $display("FAIL resume lat=%0d moved=%b pos=(%0d,%0d) want lat=%0d moved=1 pos=(36,34)", lat, moved, pos_x, pos_y, LAT);
    end
  endtask

  initial begin
    test_reset();
`ifdef PLAYER_COLLISION_EN
    test_right_blocked();
    test_up_move();
    test_partial_walls();
`else
    test_nocoll_down();
`endif
    test_goal_edge();
    test_back_to_back();
    test_state_leave();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (addr_leak != 0 || excl_bad != 0) begin
      failures++; $display("FAIL bus_and_pulses addr_leak=%0d excl_bad=%0d want 0 0", addr_leak, excl_bad);
    end
`ifndef PLAYER_COLLISION_EN
    checks++;
    if (rd_seen != 0) begin failures++; $display("FAIL map_rd_idle reads=%0d want=0", rd_seen); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameter START_X, default 36, start column (cell units, 0..37) of player top-left cell.
REQ-002 Parameter START_Y, default 35, start row (cell units, 0..37) of player top-left cell.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 state  input  4  game state; STAGE1=2, STAGE2=4, STAGE3=6 are play states, every other value is non-play.
REQ-006 move_req  input  1  single-cycle request to move one cell.
REQ-007 dir  input  2  direction sampled with move_req: 0=up, 1=down, 2=left, 3=right.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 map_rd  output  1  map cell read strobe.
REQ-010 map_x, map_y  output  6 each  cell address of the read, valid while map_rd=1.
REQ-011 map_wall  input  1  wall bit of the cell addressed one cycle earlier.
REQ-012 pos_x, pos_y  output  6 each  current player top-left cell; player occupies 4x4 cells.
REQ-013 moved, blocked, goal  output  1 each  single-cycle result pulses.

Function
REQ-014 The maze grid is 41x41 cells; legal top-left positions are 0..37 on each axis.
REQ-015 FSM states: IDLE, CHECK, WAIT, DONE.
REQ-016 IDLE: move_req=1 and state in a play state -> latch dir and target position, go to CHECK; otherwise stay in IDLE.
REQ-017 Edge rule: up with pos_y=0, down with pos_y=37, left with pos_x=0 or right with pos_x=37 -> skip CHECK/WAIT, go directly to DONE with result blocked.
REQ-018 CHECK: lasts 4 cycles with map_rd=1, reading the leading-edge cells k=0..3 in order: up (pos_x+k, pos_y-1); down (pos_x+k, pos_y+4); left (pos_x-1, pos_y+k); right (pos_x+4, pos_y+k).
REQ-019 CHECK: OR map_wall into a hit flag on each of the cycles 2..4 of CHECK; WAIT (1 cycle) ORs in the response to the 4th read.
REQ-020 WAIT -> DONE; at that edge pos updates to the target if hit=0, and is unchanged if hit=1.
REQ-021 DONE (1 cycle): moved=1 if the move succeeded, blocked=1 otherwise; goal=1 together with moved when the new pos_x=0; then go to IDLE.
REQ-022 Latency: request accepted at edge N; pos and result pulse are visible in the cycle after edge N+6 (N+1 for edge-blocked requests).
REQ-023 move_req while busy=1 is ignored and not queued; a request arriving in the same cycle as DONE is ignored.
REQ-024 map_rd=0 and map_x/map_y=0 outside CHECK.
REQ-025 If state leaves the play states in any FSM state: go to IDLE next edge, pos reloads START_X/START_Y, no result pulse is issued.
REQ-026 While in a non-play state, pos is held at START_X/START_Y.
REQ-027 moved, blocked and goal are mutually exclusive, except that goal always accompanies moved.

Reset
REQ-028 rst_n=0 asynchronously forces: FSM to IDLE, pos_x=START_X, pos_y=START_Y, busy=0, map_rd=0, map_x=0, map_y=0, moved=0, blocked=0, goal=0, hit flag cleared.
REQ-029 Reset asserted mid-operation discards the pending move with no pulse.
REQ-030 Operation resumes on the first rising clk edge after rst_n rises.

Configuration
REQ-031 Macro PLAYER_COLLISION_EN: when defined, CHECK/WAIT collision detection operates as in REQ-018..REQ-020.
REQ-032 When PLAYER_COLLISION_EN is undefined: map_rd stays 0, the edge rule (REQ-017) still applies, and every in-range request goes IDLE -> DONE with moved=1 one cycle after acceptance.

Verification
REQ-033 Reset, state=2, move_req dir=3 at pos (36,35) -> edge rule does not fire (36<37); reads cols 40 rows 35..38; bench returns wall=1 -> blocked pulse at N+6, pos stays (36,35).
REQ-034 pos (36,35), dir=0, bench map returns wall=0 for (36..39,34) -> 4 reads in order x=36,37,38,39 at y=34; moved at N+6; pos=(36,34).
REQ-035 Bench drives pos to (1,17), dir=2, cells (0,17..20) clear -> moved and goal pulse together, pos=(0,17); a following dir=2 -> blocked at N+1 with map_rd never asserted.
REQ-036 move_req asserted on every cycle of a move -> exactly one result pulse; the extra requests are ignored.
REQ-037 state changes 2->3 during CHECK -> no pulse; pos=(START_X,START_Y); busy=0 next cycle; move_req with state=3 is ignored.
REQ-038 Build without PLAYER_COLLISION_EN, dir=1 from (36,35) with bench wall=1 everywhere -> moved at N+1, pos=(36,36), map_rd always 0.
